candy_div: RTL

- Multi-cycle radix-2 restoring divider for the candy core's EX stage.
- Sits directly downstream of the ALU and consumes its divide-request bundle (operands, start, signed flag).
- Returns the quotient and a ready flag back to the ALU, which holds its pipeline-stall request until ready is seen.
- One quotient bit per cycle; signed and unsigned operation; divide-by-zero is handled explicitly.

---
 rtl/candy_div.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/candy_div.sv
// Radix-2 restoring divider for the candy EX stage: one quotient bit per cycle,
// signed/unsigned operation, explicit divide-by-zero path, flush and ALU-driven abort.
module candy_div #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             start_i,
    input  logic             annul_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             ready_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] partRem_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic             signQuot_q;
    logic             signRem_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] remOut_q;
    logic             ready_q;

    logic             op1Neg;
    logic             op2Neg;
    logic [WIDTH-1:0] absOp1;
    logic [WIDTH-1:0] absOp2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             quotBit;
    logic [WIDTH-1:0] partRem_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] quotFinal;
    logic [WIDTH-1:0] remFinal;

    // dividend_q doubles as the quotient shift register: each iteration consumes
    // its MSB and appends the new quotient bit at the LSB
    always_comb begin
        op1Neg    = signed_div_i & opdata1_i[WIDTH-1];
        op2Neg    = signed_div_i & opdata2_i[WIDTH-1];
        absOp1    = op1Neg ? -opdata1_i : opdata1_i;
        absOp2    = op2Neg ? -opdata2_i : opdata2_i;
        shifted   = {partRem_q, dividend_q[WIDTH-1]};
        trial     = shifted - {1'b0, divisor_q};
        quotBit   = ~trial[WIDTH];
        partRem_d = quotBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_d    = {dividend_q[WIDTH-2:0], quotBit};
        quotFinal = signQuot_q ? -quot_d : quot_d;
        remFinal  = signRem_q ? -partRem_d : partRem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FREE;
            count_q    <= '0;
            partRem_q  <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signQuot_q <= 1'b0;
            signRem_q  <= 1'b0;
            result_q   <= '0;
            remOut_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    result_q <= '0;
                    remOut_q <= '0;
                    ready_q  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q    <= BYZERO;
                            dividend_q <= opdata1_i;
                        end else begin
                            state_q    <= ON;
                            dividend_q <= absOp1;
                            divisor_q  <= absOp2;
                            signQuot_q <= op1Neg ^ op2Neg;
                            signRem_q  <= op1Neg;
                            count_q    <= '0;
                            partRem_q  <= '0;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i || !start_i) begin
                        state_q <= FREE;
                    end else begin
                        state_q  <= END;
                        result_q <= '1;
                        remOut_q <= dividend_q;
                        ready_q  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i || !start_i) begin
                        state_q <= FREE;
                        count_q <= '0;
                    end else begin
                        partRem_q  <= partRem_d;
                        dividend_q <= quot_d;
                        count_q    <= count_q + 1'b1;
                        // last iteration also applies sign fix-up and publishes
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_q  <= END;
                            result_q <= quotFinal;
                            remOut_q <= remFinal;
                            ready_q  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        state_q  <= FREE;
                        count_q  <= '0;
                        result_q <= '0;
                        remOut_q <= '0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FREE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign rem_o    = remOut_q;
    assign ready_o  = ready_q;

endmodule
